// File: rtl/scoreboard_round_ctrl.sv
// Round sequencer for the simple scoreboard: clears it, skips pushes, tags the magic packet
// and records pass/fail. Optional TRACK timeout with abort when SCB_ROUND_TIMEOUT_EN is defined.
module scoreboard_round_ctrl #(
    parameter int unsigned SKIPW   = 4,
    parameter int unsigned CNTW    = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [SKIPW-1:0] cfg_skip,
    input  logic            push,
    input  logic            sb_en,
    input  logic            sb_data_out_vld,
    input  logic            sb_prop_signal,
    output logic            sb_start,
    output logic            sb_rst,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic            capture_err,
`ifdef SCB_ROUND_TIMEOUT_EN
    output logic            timeout,
`endif
    output logic [CNTW-1:0] pass_cnt,
    output logic [CNTW-1:0] fail_cnt,
    output logic [CNTW-1:0] round_cnt
);

    typedef enum logic [2:0] {StIdle, StClear, StArm, StTrack, StDone} state_e;

    localparam logic [CNTW-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [SKIPW-1:0] skip_q, skip_d;
    logic [CNTW-1:0]  pass_q, pass_d;
    logic [CNTW-1:0]  fcnt_q, fcnt_d;
    logic [CNTW-1:0]  round_q, round_d;
    logic             fail_q, fail_d;
    logic             cap_q, cap_d;

`ifdef SCB_ROUND_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;
`endif

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] x);
        return (x == CntMax) ? x : x + CNTW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        pass_d  = pass_q;
        fcnt_d  = fcnt_q;
        round_d = round_q;
        fail_d  = fail_q;
        cap_d   = cap_q;
`ifdef SCB_ROUND_TIMEOUT_EN
        wait_d    = wait_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            StIdle: begin
                if (go) begin
                    skip_d  = cfg_skip;
                    state_d = StClear;
                end
            end
            StClear: state_d = StArm;
            StArm: begin
                if (push) begin
                    if (skip_q != '0) begin
                        skip_d = skip_q - SKIPW'(1);
                    end else begin
                        // Scoreboard captures this push as the magic packet.
                        state_d = StTrack;
`ifdef SCB_ROUND_TIMEOUT_EN
                        wait_d  = '0;
`endif
                    end
                end
            end
            StTrack: begin
                if (!sb_en) cap_d = 1'b1;
                if (sb_data_out_vld) begin
                    if (!sb_prop_signal) begin
                        fail_d = 1'b1;
                        fcnt_d = sat_inc(fcnt_q);
                    end else begin
                        pass_d = sat_inc(pass_q);
                    end
                    state_d = StDone;
                end
`ifdef SCB_ROUND_TIMEOUT_EN
                // Exit wins over a coincident timeout.
                else if (wait_q == WaitW'(TIMEOUT - 1)) begin
                    fail_d    = 1'b1;
                    fcnt_d    = sat_inc(fcnt_q);
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
`endif
            end
            StDone: begin
                round_d = sat_inc(round_q);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            skip_q  <= '0;
            pass_q  <= '0;
            fcnt_q  <= '0;
            round_q <= '0;
            fail_q  <= 1'b0;
            cap_q   <= 1'b0;
`ifdef SCB_ROUND_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            pass_q  <= pass_d;
            fcnt_q  <= fcnt_d;
            round_q <= round_d;
            fail_q  <= fail_d;
            cap_q   <= cap_d;
`ifdef SCB_ROUND_TIMEOUT_EN
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign sb_rst      = rst | (state_q == StClear);
    assign sb_start    = (state_q == StArm) && (skip_q == '0);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign fail        = fail_q;
    assign capture_err = cap_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fcnt_q;
    assign round_cnt   = round_q;
`ifdef SCB_ROUND_TIMEOUT_EN
    assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_scoreboard_round_ctrl.sv
// Directed/randomized bench for scoreboard_round_ctrl against a round-level reference model.
// Also exercises the TRACK timeout when SCB_ROUND_TIMEOUT_EN is defined.
module tb_scoreboard_round_ctrl;

    logic       clk = 1'b0;
    logic       rst, go, push, sb_en, sb_data_out_vld, sb_prop_signal;
    logic [3:0] cfg_skip;
    logic       sb_start, sb_rst, busy, done, fail, capture_err;
    logic [7:0] pass_cnt, fail_cnt, round_cnt;
`ifdef SCB_ROUND_TIMEOUT_EN
    logic       timeout;
    bit         exp_to;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int exp_pass, exp_fcnt, exp_round;
    bit exp_fail, exp_cap;

    always #5 clk = ~clk;

    scoreboard_round_ctrl #(
        .SKIPW  (4),
        .CNTW   (8),
        .TIMEOUT(64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .go             (go),
        .cfg_skip       (cfg_skip),
        .push           (push),
        .sb_en          (sb_en),
        .sb_data_out_vld(sb_data_out_vld),
        .sb_prop_signal (sb_prop_signal),
        .sb_start       (sb_start),
        .sb_rst         (sb_rst),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .capture_err    (capture_err),
`ifdef SCB_ROUND_TIMEOUT_EN
        .timeout        (timeout),
`endif
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .round_cnt      (round_cnt)
    );

    function automatic int sat(input int x);
        return (x >= 255) ? 255 : x + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        exp_pass  = 0;
        exp_fcnt  = 0;
        exp_round = 0;
        exp_fail  = 1'b0;
        exp_cap   = 1'b0;
`ifdef SCB_ROUND_TIMEOUT_EN
        exp_to    = 1'b0;
`endif
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_pass_cnt"}, pass_cnt, exp_pass);
        chk({tag, "_fail_cnt"}, fail_cnt, exp_fcnt);
        chk({tag, "_round_cnt"}, round_cnt, exp_round);
        chk({tag, "_fail"}, fail, exp_fail);
        chk({tag, "_capture_err"}, capture_err, exp_cap);
`ifdef SCB_ROUND_TIMEOUT_EN
        chk({tag, "_timeout"}, timeout, exp_to);
`endif
    endtask

    // One full round: go, CLEAR, idle ARM cycles, skip pushes, tag push, TRACK latency, exit.
    task automatic run_round(input int skip, input bit prop, input bit en_ok);
        int gap;
        go = 1'b1;
        cfg_skip = 4'(skip);
        #1 chk("idle_busy", busy, 0);
        step;
        go   = 1'($urandom_range(0, 1));
        push = 1'($urandom_range(0, 1));
        #1 chk("clear_sb_rst", sb_rst, 1);
        chk("clear_busy", busy, 1);
        chk("clear_start", sb_start, 0);
        step;
        push = 1'b0;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            go = 1'($urandom_range(0, 1));
            #1 chk("arm_idle_start", sb_start, skip == 0);
            step;
        end
        go = 1'b0;
        for (int i = 0; i <= skip; i++) begin
            push = 1'b1;
            #1 chk("arm_start", sb_start, i == skip);
            step;
        end
        push  = 1'b0;
        sb_en = en_ok;
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            go   = 1'($urandom_range(0, 1));
            push = 1'($urandom_range(0, 1));
            #1 chk("track_done", done, 0);
            chk("track_busy", busy, 1);
            step;
        end
        push            = 1'b0;
        sb_data_out_vld = 1'b1;
        sb_prop_signal  = prop;
        go              = 1'($urandom_range(0, 1));
        step;
        sb_data_out_vld = 1'b0;
        sb_prop_signal  = 1'($urandom_range(0, 1));
        if (prop) exp_pass = sat(exp_pass);
        else begin
            exp_fcnt = sat(exp_fcnt);
            exp_fail = 1'b1;
        end
        if (!en_ok) exp_cap = 1'b1;
        go = 1'b1;
        #1 chk("done_pulse", done, 1);
        check_counts("done");
        step;
        go = 1'b0;
        exp_round = sat(exp_round);
        #1 chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        check_counts("after");
        sb_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        push = 1'b0;
        sb_en = 1'b0;
        sb_data_out_vld = 1'b0;
        sb_prop_signal = 1'b0;
        cfg_skip = '0;
        model_clear();

        step;
        chk("rst_sb_rst", sb_rst, 1);
        step;
        chk("rst_sb_rst2", sb_rst, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1 chk("post_rst_sb_rst", sb_rst, 0);
        step;
        chk("idle_busy0", busy, 0);
        chk("idle_start0", sb_start, 0);
        check_counts("idle");

        run_round(2, 1'b1, 1'b1);
        run_round(0, 1'b0, 1'b1);
        run_round($urandom_range(0, 5), 1'b1, 1'b1);
        run_round(1, 1'b1, 1'b0);

        // Reset while tracking
        go = 1'b1;
        cfg_skip = 4'd0;
        step;
        go = 1'b0;
        step;
        push = 1'b1;
        step;
        push  = 1'b0;
        sb_en = 1'b1;
        step;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1 chk("midrst_sb_rst", sb_rst, 1);
        step;
        model_clear();
        chk("midrst_busy", busy, 0);
        chk("midrst_sb_rst2", sb_rst, 1);
        check_counts("midrst");
        rst = 1'b0;
        sb_data_out_vld = 1'b1;
        sb_prop_signal  = 1'b1;
        step;
        sb_data_out_vld = 1'b0;
        sb_en = 1'b0;
        chk("late_vld_done", done, 0);
        chk("late_vld_busy", busy, 0);
        check_counts("late_vld");

        for (int r = 0; r < 300; r++) run_round($urandom_range(0, 3), 1'b1, 1'b1);
        chk("sat_pass_cnt", pass_cnt, 255);
        chk("sat_round_cnt", round_cnt, 255);

        for (int r = 0; r < 6; r++)
            run_round($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1);

`ifdef SCB_ROUND_TIMEOUT_EN
        rst = 1'b1;
        step;
        rst = 1'b0;
        model_clear();
        go = 1'b1;
        cfg_skip = 4'd0;
        step;
        go = 1'b0;
        step;
        push = 1'b1;
        step;
        push  = 1'b0;
        sb_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1 chk("to_wait_done", done, 0);
            step;
        end
        exp_fcnt = 1;
        exp_fail = 1'b1;
        exp_to   = 1'b1;
        chk("to_done", done, 1);
        check_counts("to");
        step;
        exp_round = 1;
        chk("to_idle_busy", busy, 0);
        check_counts("to_after");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
